serial_tx_link: RTL

Per-output-port serialiser that sits directly downstream of the router's arbitration/crossbar stage. It captures one parallel flit (payload + destination address) on the cycle the crossbar enables its port and shifts it onto a single-bit link. It then holds the port busy until the neighbouring router acknowledges the frame, retransmitting after a timeout if no acknowledge arrives. One instance exists per output direction (N, E, S, W, L).

---
 rtl/serial_tx_link_if.sv | 31 +++
 rtl/serial_tx_link.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/serial_tx_link_if.sv
// serial_tx_link_if: groups the crossbar load port and the serial link of one
// serial_tx_link instance. "slave" is the serialiser side; "master" is the
// crossbar plus downstream receiver seen from the serialiser.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 4
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

interface serial_tx_link_if #(
  parameter int WIDTH = `PAYLOAD_SIZE + `ADDR_BITS
);
  logic [WIDTH-1:0] item_in;
  logic             ena;
  logic             busy;
  logic             tx_bit;
  logic             tx_frame;
  logic             tx_ack;
  logic             retry;

  modport master (
    output item_in, ena, tx_ack,
    input  busy, tx_bit, tx_frame, retry
  );

  modport slave (
    input  item_in, ena, tx_ack,
    output busy, tx_bit, tx_frame, retry
  );
endinterface

// File: rtl/serial_tx_link.sv
// serial_tx_link: per-output-port serialiser. Captures one flit when the
// crossbar enables the port, shifts it LSB first onto a single-bit link, then
// holds the port busy until the neighbour acknowledges, retransmitting after
// ACK_TIMEOUT idle cycles (0 = wait forever).
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit
// (XOR of the flit) as the last frame bit.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 4
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 4
`endif

module serial_tx_link #(
  parameter int id          = -1,
  parameter int WIDTH       = `PAYLOAD_SIZE + `ADDR_BITS,
  parameter int ACK_TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  serial_tx_link_if.slave  link
);

`ifdef SERIAL_TX_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam int BIT_W = (FRAME_LEN < 2) ? 1 : $clog2(FRAME_LEN);
  localparam int TO_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_LEN - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  // Even parity of a flit: XOR of all its bits.
  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  // Frame as it goes on the wire, bit 0 first; parity (if enabled) last.
  function automatic logic [FRAME_LEN-1:0] make_frame(input logic [WIDTH-1:0] d);
`ifdef SERIAL_TX_PARITY_EN
    return {even_parity(d), d};
`else
    return d;
`endif
  endfunction

  state_t               state_r;
  logic [WIDTH-1:0]     hold_r;
  logic [FRAME_LEN-1:0] shift_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [TO_W-1:0]      to_cnt_r;
  logic                 busy_r;
  logic                 tx_bit_r;
  logic                 tx_frame_r;
  logic                 retry_r;

  // Frame FSM: all outputs registered so the link sees no input-to-output path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      hold_r     <= '0;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      to_cnt_r   <= '0;
      busy_r     <= 1'b0;
      tx_bit_r   <= 1'b0;
      tx_frame_r <= 1'b0;
      retry_r    <= 1'b0;
    end else begin
      retry_r <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r     <= 1'b0;
          tx_frame_r <= 1'b0;
          tx_bit_r   <= 1'b0;
          if (link.ena) begin
            // First bit is driven straight from the input so it appears E0+.
            hold_r     <= link.item_in;
            shift_r    <= make_frame(link.item_in);
            bit_cnt_r  <= '0;
            busy_r     <= 1'b1;
            tx_frame_r <= 1'b1;
            tx_bit_r   <= link.item_in[0];
            state_r    <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end

        SHIFT: begin
          // tx_ack and ena are deliberately not looked at here.
          if (bit_cnt_r == LAST_BIT) begin
            tx_frame_r <= 1'b0;
            tx_bit_r   <= 1'b0;
            to_cnt_r   <= '0;
            state_r    <= WAIT_ACK;
          end else begin
            shift_r    <= {1'b0, shift_r[FRAME_LEN-1:1]};
            tx_bit_r   <= shift_r[1];
            bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
            state_r    <= SHIFT;
          end
        end

        WAIT_ACK: begin
          tx_frame_r <= 1'b0;
          tx_bit_r   <= 1'b0;
          if (link.tx_ack) begin
            // Ack beats a coinciding timeout.
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (ACK_TIMEOUT != 0) begin
            if (to_cnt_r == TO_LAST) begin
              // Retransmit from the hold copy; busy stays high throughout.
              shift_r    <= make_frame(hold_r);
              bit_cnt_r  <= '0;
              tx_frame_r <= 1'b1;
              tx_bit_r   <= hold_r[0];
              retry_r    <= 1'b1;
              state_r    <= SHIFT;
            end else begin
              to_cnt_r <= to_cnt_r + TO_W'(1);
              state_r  <= WAIT_ACK;
            end
          end else begin
            state_r <= WAIT_ACK;
          end
        end

        default: begin
          busy_r     <= 1'b0;
          tx_frame_r <= 1'b0;
          tx_bit_r   <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign link.busy     = busy_r;
  assign link.tx_bit   = tx_bit_r;
  assign link.tx_frame = tx_frame_r;
  assign link.retry    = retry_r;

endmodule
